// File: rtl/ttfir_pkg.sv
// Shared constants, state encodings and sizing helpers for the ttfir coefficient path.
// No logic; sizing functions are evaluated at elaboration only.
package ttfir_pkg;

    localparam int N_TAPS_DEF  = 10;
    localparam int BW_COEF_DEF = 4;
    localparam int BW_CFG_DEF  = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    function automatic int beats_f(input int bw_coef, input int bw_cfg);
        return bw_coef / bw_cfg;
    endfunction

    function automatic int total_f(input int n_taps, input int bw_coef, input int bw_cfg);
        return n_taps * beats_f(bw_coef, bw_cfg);
    endfunction

    // Counter width for values 0..range-1, never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/ttfir_coef_stage.sv
// Staging bank for serial coefficient beats with beat/tap counters and a last-beat flag.
// Latency: a written beat is visible on stage the next cycle; stage_nxt merges the current beat combinationally.
// Backpressure: none; every we cycle consumes one beat.
module ttfir_coef_stage
    import ttfir_pkg::*;
#(
    parameter int N_TAPS  = N_TAPS_DEF,
    parameter int BW_COEF = BW_COEF_DEF,
    parameter int BW_CFG  = BW_CFG_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic                        clr,
    input  logic [BW_CFG-1:0]           din,
    output logic [N_TAPS*BW_COEF-1:0]   stage,
    output logic [N_TAPS*BW_COEF-1:0]   stage_nxt,
    output logic                        last
);

    localparam int BEATS = beats_f(BW_COEF, BW_CFG);
    localparam int BW_B  = cnt_w(BEATS);
    localparam int BW_T  = cnt_w(N_TAPS);

    logic [BW_B-1:0] beat_cnt;
    logic [BW_T-1:0] tap_cnt;
    logic            beat_wrap;

    assign beat_wrap = (beat_cnt == BW_B'(BEATS - 1));
    assign last      = beat_wrap && (tap_cnt == BW_T'(N_TAPS - 1));

    // Beats fill each tap least-significant chunk first, tap 0 first.
    always_comb begin
        stage_nxt = stage;
        for (int t = 0; t < N_TAPS; t++) begin
            for (int b = 0; b < BEATS; b++) begin
                if (tap_cnt == BW_T'(t) && beat_cnt == BW_B'(b)) begin
                    stage_nxt[(t*BEATS + b)*BW_CFG +: BW_CFG] = din;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage    <= '0;
            beat_cnt <= '0;
            tap_cnt  <= '0;
        end else if (clr) begin
            stage    <= '0;
            beat_cnt <= '0;
            tap_cnt  <= '0;
        end else if (we) begin
            stage <= stage_nxt;
            if (beat_wrap) begin
                beat_cnt <= '0;
                tap_cnt  <= last ? '0 : tap_cnt + BW_T'(1);
            end else begin
                beat_cnt <= beat_cnt + BW_B'(1);
            end
        end
    end

endmodule

// File: rtl/ttfir_coef_loader.sv
// Assembles serial coefficient beats, commits them atomically, flushes the FIR delay line, then runs.
// Latency: commit/abort visible one cycle after the deciding edge; flush lasts N_TAPS cycles.
// Backpressure: none; a beat is taken on every cfg_valid cycle in LOAD, beats outside LOAD are ignored.
module ttfir_coef_loader
    import ttfir_pkg::*;
#(
    parameter int N_TAPS  = N_TAPS_DEF,
    parameter int BW_coef = BW_COEF_DEF,
    parameter int BW_cfg  = BW_CFG_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_mode,
    input  logic                        cfg_valid,
    input  logic [BW_cfg-1:0]           cfg_data,
    output logic [N_TAPS*BW_coef-1:0]   coef_out,
    output logic                        fir_en,
    output logic                        flush,
    output logic                        load_busy,
    output logic                        load_done,
    output logic                        load_err
);

    localparam int BW_F = cnt_w(N_TAPS);

    logic [1:0]                  state_q;
    logic [1:0]                  state_d;
    logic [BW_F-1:0]             fcnt_q;
    logic                        stg_we;
    logic                        stg_clr;
    logic                        stg_last;
    logic                        commit;
    logic                        abort;
    logic [N_TAPS*BW_coef-1:0]   stg_bank;
    logic [N_TAPS*BW_coef-1:0]   stg_nxt;

    ttfir_coef_stage #(
        .N_TAPS  (N_TAPS),
        .BW_COEF (BW_coef),
        .BW_CFG  (BW_cfg)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .we        (stg_we),
        .clr       (stg_clr),
        .din       (cfg_data),
        .stage     (stg_bank),
        .stage_nxt (stg_nxt),
        .last      (stg_last)
    );

    always_comb begin
        state_d = state_q;
        stg_we  = 1'b0;
        stg_clr = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: state_d = cfg_mode ? ST_LOAD : ST_FLUSH;
            ST_LOAD: begin
                // Dropping cfg_mode wins over a coincident beat.
                if (!cfg_mode) begin
                    abort   = 1'b1;
                    stg_clr = 1'b1;
                    state_d = ST_FLUSH;
                end else if (cfg_valid) begin
                    stg_we = 1'b1;
                    if (stg_last) begin
                        commit  = 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == BW_F'(N_TAPS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_mode) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fcnt_q    <= '0;
            coef_out  <= '0;
            fir_en    <= 1'b0;
            flush     <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= (state_q == ST_FLUSH && state_d == ST_FLUSH) ? fcnt_q + BW_F'(1) : '0;
            fir_en    <= (state_d == ST_RUN);
            flush     <= (state_d == ST_FLUSH);
            load_busy <= (state_d == ST_LOAD);
            load_done <= commit;
            load_err  <= abort;
            if (commit) begin
                coef_out <= stg_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ttfir_coef_loader.sv
// Directed + randomized bench for ttfir_coef_loader against a beat-assembly reference model.
module tb_ttfir_coef_loader;
    import ttfir_pkg::*;

    localparam int NT    = N_TAPS_DEF;
    localparam int BWC   = BW_COEF_DEF;
    localparam int BWG   = BW_CFG_DEF;
    localparam int BEATS = BWC / BWG;
    localparam int TOTAL = NT * BEATS;
    localparam int W     = NT * BWC;

    logic           clk;
    logic           rst;
    logic           cfg_mode;
    logic           cfg_valid;
    logic [BWG-1:0] cfg_data;
    logic [W-1:0]   coef_out;
    logic           fir_en;
    logic           flush;
    logic           load_busy;
    logic           load_done;
    logic           load_err;

    ttfir_coef_loader #(.N_TAPS(NT), .BW_coef(BWC), .BW_cfg(BWG)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .coef_out  (coef_out),
        .fir_en    (fir_en),
        .flush     (flush),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] committed;
    logic [BWG-1:0] beats [TOTAL];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Coefficient t = sum over its beats of beat_b * 2^(BWG*b), placed at bit BWC*t.
    function automatic logic [W-1:0] assemble();
        logic [63:0] acc = 64'd0;
        for (int t = 0; t < NT; t++)
            for (int b = 0; b < BEATS; b++)
                acc += 64'(beats[t*BEATS + b]) << (BWG*b + BWC*t);
        return acc[W-1:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".coef"}, 64'(coef_out), 64'd0);
        chk({tag, ".fir_en"}, 64'(fir_en), 64'd0);
        chk({tag, ".flush"}, 64'(flush), 64'd0);
        chk({tag, ".busy"}, 64'(load_busy), 64'd0);
        chk({tag, ".done"}, 64'(load_done), 64'd0);
        chk({tag, ".err"}, 64'(load_err), 64'd0);
    endtask

    // Called in the first cycle after the edge that entered FLUSH.
    task automatic check_flush(input string tag, input bit hold_mode);
        for (int i = 0; i < NT; i++) begin
            chk({tag, ".flush_hi"}, 64'(flush), 64'd1);
            chk({tag, ".flush_fir_en"}, 64'(fir_en), 64'd0);
            if (i > 0) chk({tag, ".flush_pulse"}, 64'(load_done | load_err), 64'd0);
            cfg_mode  = hold_mode;
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data  = BWG'($urandom);
            tick();
        end
        chk({tag, ".run_fir_en"}, 64'(fir_en), 64'd1);
        chk({tag, ".run_flush"}, 64'(flush), 64'd0);
        chk({tag, ".run_coef"}, 64'(coef_out), 64'(committed));
        cfg_valid = 1'b0;
    endtask

    // Starts from RUN; abort_at < 0 means a complete load.
    task automatic do_load(input string tag, input int gap, input int abort_at,
                           input bit abort_valid, input bit hold_next);
        cfg_mode  = 1'b1;
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_data  = BWG'($urandom);
        tick();
        chk({tag, ".enter_busy"}, 64'(load_busy), 64'd1);
        chk({tag, ".enter_fir_en"}, 64'(fir_en), 64'd0);
        for (int i = 0; i < TOTAL; i++) begin
            if (i == abort_at) begin
                cfg_mode  = 1'b0;
                cfg_valid = abort_valid;
                cfg_data  = beats[i];
                tick();
                chk({tag, ".abort_err"}, 64'(load_err), 64'd1);
                chk({tag, ".abort_done"}, 64'(load_done), 64'd0);
                chk({tag, ".abort_busy"}, 64'(load_busy), 64'd0);
                chk({tag, ".abort_coef"}, 64'(coef_out), 64'(committed));
                check_flush(tag, 1'b0);
                return;
            end
            cfg_valid = 1'b1;
            cfg_data  = beats[i];
            tick();
            if (i < TOTAL - 1) begin
                chk({tag, ".mid_coef"}, 64'(coef_out), 64'(committed));
                chk({tag, ".mid_done"}, 64'(load_done), 64'd0);
                chk({tag, ".mid_busy"}, 64'(load_busy), 64'd1);
                for (int g = 0; g < gap; g++) begin
                    cfg_valid = 1'b0;
                    cfg_data  = BWG'($urandom);
                    tick();
                end
            end
        end
        committed = assemble();
        chk({tag, ".done"}, 64'(load_done), 64'd1);
        chk({tag, ".commit_coef"}, 64'(coef_out), 64'(committed));
        chk({tag, ".commit_busy"}, 64'(load_busy), 64'd0);
        chk({tag, ".commit_err"}, 64'(load_err), 64'd0);
        check_flush(tag, hold_next);
    endtask

    task automatic set_ramp_beats();
        for (int t = 0; t < NT; t++) begin
            logic [BWC-1:0] v = BWC'(t + 1);
            for (int b = 0; b < BEATS; b++) beats[t*BEATS + b] = v[b*BWG +: BWG];
        end
    endtask

    task automatic set_random_beats();
        for (int i = 0; i < TOTAL; i++) beats[i] = BWG'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfg_mode  = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        committed = '0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_flush("boot", 1'b0);

        set_ramp_beats();
        do_load("ramp", 0, -1, 1'b0, 1'b0);
        chk("ramp_vec", 64'(coef_out), 64'hA987654321);

        do_load("gap3", 3, -1, 1'b0, 1'b1);
        chk("gap3_vec", 64'(coef_out), 64'hA987654321);

        set_random_beats();
        do_load("abort7", 0, 7, 1'b0, 1'b0);
        chk("abort7_vec", 64'(coef_out), 64'hA987654321);

        do_load("abort19", 1, 19, 1'b1, 1'b0);
        chk("abort19_vec", 64'(coef_out), 64'hA987654321);

        for (int n = 0; n < 4; n++) begin
            set_random_beats();
            do_load("rand", $urandom_range(0, 2), -1, 1'b0, n[0]);
        end

        set_random_beats();
        cfg_mode = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = beats[i];
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        committed = '0;
        @(negedge clk);
        rst       = 1'b0;
        cfg_mode  = 1'b0;
        cfg_valid = 1'b0;
        tick();
        check_flush("post_rst", 1'b0);

        for (int i = 0; i < TOTAL; i++) beats[i] = '1;
        do_load("all_f", 0, -1, 1'b0, 1'b0);
        chk("all_f_vec", 64'(coef_out), 64'hFFFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
